dds_sweep_ctrl: RTL and testbench

//  Sequencer driving the DDS frq_ctrl/pha_ctrl control words. On a start pulse it

---
 rtl/dds_sweep_ctrl.sv | 139 +++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the DDS: steps frq_ctrl from f_start to f_stop,
// holding each word dwell+1 clocks, in single-shot or continuous mode with abort.
module dds_sweep_ctrl #(
   parameter int FW = 8,
   parameter int PW = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic          mode_cont,
   input  logic [FW-1:0] f_start,
   input  logic [FW-1:0] f_stop,
   input  logic [FW-1:0] f_step,
   input  logic [DW-1:0] dwell,
   input  logic [PW-1:0] pha_in,
   output logic [FW-1:0] frq_ctrl,
   output logic [PW-1:0] pha_ctrl,
   output logic          step_stb,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DWELL,
      S_DONE
   } state_t;

   state_t        state;
   logic [FW-1:0] f_start_l;
   logic [FW-1:0] f_stop_l;
   logic [FW-1:0] f_step_l;
   logic [DW-1:0] dwell_l;
   logic [PW-1:0] pha_l;
   logic          mode_l;
   logic [DW-1:0] cnt;

   logic          sweep_up;
   logic          at_stop;
   logic [FW:0]   sum;
   logic [FW:0]   diff;
   logic [FW-1:0] nxt;

   // Next word is computed one bit wider so a carry or borrow clamps to f_stop
   // instead of wrapping modulo 2^FW.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      sweep_up = (f_stop_l >= f_start_l);
      at_stop  = (frq_ctrl == f_stop_l);
      sum      = {1'b0, frq_ctrl} + {1'b0, f_step_l};
      diff     = {1'b0, frq_ctrl} - {1'b0, f_step_l};
      nxt      = f_stop_l;
      if (sweep_up) begin
         if (sum <= {1'b0, f_stop_l})
            nxt = sum[FW-1:0];
      end else begin
         if (!diff[FW] && (diff[FW-1:0] >= f_stop_l))
            nxt = diff[FW-1:0];
      end
   end

   // NOTE: state and outputs use non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   // NOTE: the latched config is a handful of flops, not a memory, so it is cleared on
   // reset along with everything else.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         f_start_l <= '0;
         f_stop_l  <= '0;
         f_step_l  <= '0;
         dwell_l   <= '0;
         pha_l     <= '0;
         mode_l    <= 1'b0;
         cnt       <= '0;
         frq_ctrl  <= '0;
         pha_ctrl  <= '0;
         step_stb  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         step_stb <= 1'b0;
         done     <= 1'b0;
         if (abort && (state != S_IDLE)) begin
            // Abort parks the DDS at zero frequency but leaves the phase word alone.
            state    <= S_IDLE;
            frq_ctrl <= '0;
            busy     <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start && !abort) begin
                     f_start_l <= f_start;
                     f_stop_l  <= f_stop;
                     f_step_l  <= f_step;
                     dwell_l   <= dwell;
                     pha_l     <= pha_in;
                     mode_l    <= mode_cont;
                     busy      <= 1'b1;
                     state     <= S_LOAD;
                  end
               end
               S_LOAD: begin
                  frq_ctrl <= f_start_l;
                  pha_ctrl <= pha_l;
                  cnt      <= dwell_l;
                  step_stb <= 1'b1;
                  state    <= S_DWELL;
               end
               S_DWELL: begin
                  if (cnt != '0) begin
                     cnt <= cnt - 1'b1;
                  end else if (!at_stop) begin
                     frq_ctrl <= nxt;
                     cnt      <= dwell_l;
                     step_stb <= 1'b1;
                  end else if (mode_l) begin
                     state <= S_LOAD;
                  end else begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_DONE;
                  end
               end
               S_DONE: begin
                  state <= S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: a reference sweep model fills a queue of
// expected frequency words, which are popped and compared on every step_stb.
module tb_dds_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic        mode_cont;
   logic [7:0]  f_start;
   logic [7:0]  f_stop;
   logic [7:0]  f_step;
   logic [15:0] dwell;
   logic [7:0]  pha_in;
   logic [7:0]  frq_ctrl;
   logic [7:0]  pha_ctrl;
   logic        step_stb;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;
   int exp_q[$];

   dds_sweep_ctrl #(.FW(8), .PW(8), .DW(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .mode_cont (mode_cont),
      .f_start   (f_start),
      .f_stop    (f_stop),
      .f_step    (f_step),
      .dwell     (dwell),
      .pha_in    (pha_in),
      .frq_ctrl  (frq_ctrl),
      .pha_ctrl  (pha_ctrl),
      .step_stb  (step_stb),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Reference sweep: plain integer arithmetic, clamped at f_stop.
   task automatic model_push(input int fs, input int fe, input int st);
      int cur;
      int n;
      cur = fs;
      exp_q.push_back(cur);
      for (int k = 0; k < 300 && cur != fe; k++) begin
         if (fe >= fs) begin
            n = cur + st;
            if (n > fe) n = fe;
         end else begin
            n = cur - st;
            if (n < fe) n = fe;
         end
         cur = n;
         exp_q.push_back(cur);
      end
   endtask

   task automatic do_start(input logic [7:0] fs, input logic [7:0] fe, input logic [7:0] st,
                           input logic [15:0] dw, input logic cont, input logic [7:0] ph);
      @(negedge clk);
      f_start = fs; f_stop = fe; f_step = st; dwell = dw; mode_cont = cont; pha_in = ph;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL start_busy: busy=%b expected 1 in LOAD", busy);
      end
   endtask

   // Pops one expected word per strobe, checks hold length, ends on done.
   task automatic monitor_single(input int dw, input logic [7:0] fe, input logic [7:0] ph,
                                 input string name);
      int  last;
      bit  got;
      int  e;
      last = -1;
      got  = 1'b0;
      for (int cyc = 0; cyc < 2000 && !got; cyc++) begin
         @(negedge clk);
         if (step_stb === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL %s_extra_stb: frq=%0d with no word expected", name, frq_ctrl);
            end else begin
               e = exp_q.pop_front();
               if (frq_ctrl !== 8'(e)) begin
                  failures++;
                  $display("FAIL %s_frq: got %0d expected %0d", name, frq_ctrl, e);
               end
            end
            checks++;
            if (pha_ctrl !== ph) begin
               failures++;
               $display("FAIL %s_pha: got %0h expected %0h", name, pha_ctrl, ph);
            end
            if (last >= 0) begin
               checks++;
               if (cyc - last != dw + 1) begin
                  failures++;
                  $display("FAIL %s_hold: got %0d clks expected %0d", name, cyc - last, dw + 1);
               end
            end
            last = cyc;
         end
         if (done === 1'b1) begin
            got = 1'b1;
            checks++;
            if (cyc - last != dw + 1) begin
               failures++;
               $display("FAIL %s_last_hold: got %0d clks expected %0d", name, cyc - last, dw + 1);
            end
            checks++;
            if (frq_ctrl !== fe || busy !== 1'b0 || exp_q.size() != 0) begin
               failures++;
               $display("FAIL %s_done_state: frq=%0d busy=%b left=%0d expected frq=%0d busy=0 left=0",
                        name, frq_ctrl, busy, exp_q.size(), fe);
            end
         end
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: no done within 2000 clks", name);
      end
      exp_q.delete();
   endtask

   task automatic check_idle_after(input logic [7:0] fe, input string name);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || step_stb !== 1'b0 || frq_ctrl !== fe) begin
         failures++;
         $display("FAIL %s_idle: busy=%b done=%b stb=%b frq=%0d expected 0,0,0,%0d",
                  name, busy, done, step_stb, frq_ctrl, fe);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; mode_cont = 1'b0;
      f_start = 8'd0; f_stop = 8'd0; f_step = 8'd0; dwell = 16'd0; pha_in = 8'd0;
      repeat (2) @(negedge clk);
      checks++;
      if ({frq_ctrl, pha_ctrl, step_stb, busy, done} !== 19'd0) begin
         failures++;
         $display("FAIL reset_outputs: frq=%0d pha=%0d stb=%b busy=%b done=%b expected all 0",
                  frq_ctrl, pha_ctrl, step_stb, busy, done);
      end
      rst = 1'b0;
      check_idle_after(8'd0, "post_reset");
   endtask

   task automatic test_single_basic();
      model_push(10, 40, 10);
      do_start(8'd10, 8'd40, 8'd10, 16'd3, 1'b0, 8'h5A);
      monitor_single(3, 8'd40, 8'h5A, "basic");
      check_idle_after(8'd40, "basic");
   endtask

   task automatic test_clamp_fast();
      model_push(10, 35, 10);
      do_start(8'd10, 8'd35, 8'd10, 16'd0, 1'b0, 8'h01);
      monitor_single(0, 8'd35, 8'h01, "clamp");
      check_idle_after(8'd35, "clamp");
   endtask

   task automatic test_no_wrap();
      model_push(250, 5, 100);
      do_start(8'd250, 8'd5, 8'd100, 16'd1, 1'b0, 8'h22);
      monitor_single(1, 8'd5, 8'h22, "down");
      model_push(200, 255, 60);
      do_start(8'd200, 8'd255, 8'd60, 16'd2, 1'b0, 8'h23);
      monitor_single(2, 8'd255, 8'h23, "up_top");
   endtask

   task automatic test_equal_endpoints();
      model_push(77, 77, 4);
      do_start(8'd77, 8'd77, 8'd4, 16'd2, 1'b0, 8'h44);
      monitor_single(2, 8'd77, 8'h44, "equal");
   endtask

   task automatic test_back_to_back();
      model_push(1, 3, 1);
      do_start(8'd1, 8'd3, 8'd1, 16'd1, 1'b0, 8'h10);
      monitor_single(1, 8'd3, 8'h10, "b2b_first");
      // Now in the DONE cycle: this start must be ignored, then taken in IDLE.
      f_start = 8'd50; f_stop = 8'd60; f_step = 8'd5; dwell = 16'd0; pha_in = 8'h11;
      start = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL b2b_done_cycle: busy=%b done=%b expected 0,0", busy, done);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_accept: busy=%b expected 1", busy);
      end
      model_push(50, 60, 5);
      monitor_single(0, 8'd60, 8'h11, "b2b_second");
   endtask

   task automatic test_cont_abort();
      int seen;
      int e;
      seen = 0;
      do_start(8'd0, 8'd20, 8'd10, 16'd0, 1'b1, 8'h33);
      for (int cyc = 0; cyc < 100 && seen < 7; cyc++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL cont_done: done pulsed in continuous mode");
         end
         if (step_stb === 1'b1) begin
            e = (seen % 3) * 10;
            checks++;
            if (frq_ctrl !== 8'(e)) begin
               failures++;
               $display("FAIL cont_frq: got %0d expected %0d", frq_ctrl, e);
            end
            seen++;
         end
      end
      checks++;
      if (seen != 7) begin
         failures++;
         $display("FAIL cont_timeout: saw %0d strobes expected 7", seen);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (frq_ctrl !== 8'd0 || busy !== 1'b0 || step_stb !== 1'b0 || done !== 1'b0 ||
          pha_ctrl !== 8'h33) begin
         failures++;
         $display("FAIL cont_abort: frq=%0d busy=%b stb=%b done=%b pha=%0h expected 0,0,0,0,33",
                  frq_ctrl, busy, step_stb, done, pha_ctrl);
      end
      repeat (10) check_idle_after(8'd0, "cont_after_abort");
   endtask

   task automatic test_tone();
      int bad;
      int stb_cnt;
      bad = 0;
      stb_cnt = 0;
      do_start(8'd7, 8'd9, 8'd0, 16'd0, 1'b0, 8'h11);
      for (int cyc = 0; cyc < 1000; cyc++) begin
         @(negedge clk);
         if (frq_ctrl !== 8'd7 || done !== 1'b0 || busy !== 1'b1 || pha_ctrl !== 8'h11) bad++;
         if (step_stb === 1'b1) stb_cnt++;
         start = 1'b0;
         if (cyc == 10) begin
            f_start = 8'd100; f_stop = 8'd3; f_step = 8'd1; dwell = 16'd5;
            mode_cont = 1'b1; pha_in = 8'h00;
         end
         if (cyc == 20) start = 1'b1;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL tone_hold: %0d bad cycles expected 0", bad);
      end
      checks++;
      if (stb_cnt != 1000) begin
         failures++;
         $display("FAIL tone_stb: got %0d strobes expected 1000", stb_cnt);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      mode_cont = 1'b0;
      checks++;
      if (frq_ctrl !== 8'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL tone_abort: frq=%0d busy=%b expected 0,0", frq_ctrl, busy);
      end
   endtask

   task automatic test_busy_start_and_async_reset();
      int vals[2];
      int seen;
      seen = 0;
      do_start(8'd10, 8'd40, 8'd10, 16'd5, 1'b0, 8'h66);
      for (int cyc = 0; cyc < 40 && seen < 2; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (step_stb === 1'b1) begin
            vals[seen] = int'(frq_ctrl);
            seen++;
            if (seen == 1) begin
               f_start = 8'd100; f_stop = 8'd200; f_step = 8'd50; dwell = 16'd0;
               start = 1'b1;
            end
         end
      end
      checks++;
      if (seen != 2 || vals[0] != 10 || vals[1] != 20) begin
         failures++;
         $display("FAIL busy_start: seen=%0d words %0d,%0d expected 2 words 10,20",
                  seen, vals[0], vals[1]);
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({frq_ctrl, pha_ctrl, step_stb, busy, done} !== 19'd0) begin
         failures++;
         $display("FAIL async_reset: frq=%0d pha=%0d stb=%b busy=%b done=%b expected all 0",
                  frq_ctrl, pha_ctrl, step_stb, busy, done);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) check_idle_after(8'd0, "after_rst");
      model_push(5, 5, 1);
      do_start(8'd5, 8'd5, 8'd1, 16'd0, 1'b0, 8'h77);
      monitor_single(0, 8'd5, 8'h77, "recover");
   endtask

   initial begin
      test_reset();
      test_single_basic();
      test_clamp_fast();
      test_no_wrap();
      test_equal_endpoints();
      test_back_to_back();
      test_cont_abort();
      test_tone();
      test_busy_start_and_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
